// File: rtl/snowbro2_sndbus.sv
// Sound-bus front end: CPU strobes in, YM2151/OKI M6295 chip-side write sequencing out.
// YM2151 writes are queued and drained by a busy-aware sequencer; all logic is on CLK96.
module snowbro2_sndbus #(
    parameter int FIFO_AW     = 3,
    parameter int WR_HOLD     = 4,
    parameter int BUSY_SETTLE = 8,
    parameter int BUSY_TMO    = 1023
) (
    input  logic       CLK96,
    input  logic       RESET96_N,
    input  logic       CPU_WR,
    input  logic       CPU_RD,
    input  logic [1:0] CPU_ADDR,
    input  logic [7:0] CPU_DIN,
    output logic [7:0] CPU_DOUT,
    output logic       CPU_WAIT,
    output logic       YM2151_CS,
    output logic       YM2151_WE,
    output logic       YM2151_WR_CMD,
    output logic [7:0] YM2151_DIN,
    input  logic [7:0] YM2151_DOUT,
    output logic       OKI_WE,
    output logic [7:0] OKI_DIN,
    input  logic [7:0] OKI_DOUT,
    output logic       OKI_BANK,
    output logic       DROP
);

    localparam int DEPTH = 1 << FIFO_AW;

    // One shared down-the-line counter width covers hold, settle and busy-timeout counts.
    localparam int CNT_MAX = (BUSY_TMO > BUSY_SETTLE)
                           ? ((BUSY_TMO > WR_HOLD) ? BUSY_TMO : WR_HOLD)
                           : ((BUSY_SETTLE > WR_HOLD) ? BUSY_SETTLE : WR_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(WR_HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(BUSY_SETTLE - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(BUSY_TMO);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    ym_cnt;
    logic [CW-1:0]    oki_cnt;

    logic [8:0]       fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [8:0]       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;

    logic             ym_wr_req;
    logic             oki_wr_req;
    logic             ym_go;
    logic             ym_pending;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                        (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    assign ym_wr_req  = CPU_WR && !CPU_ADDR[1];
    assign oki_wr_req = CPU_WR && (CPU_ADDR == 2'd2);

    // Address writes never wait on busy; data writes wait for busy low or the timeout.
    assign ym_go      = !fifo_head[8] || !YM2151_DOUT[7] || (ym_cnt == TMO_LAST);
    assign fifo_pop   = (state == ST_CHECK) && ym_go;
    assign fifo_push  = ym_wr_req && (!fifo_full || fifo_pop);
    assign ym_pending = !fifo_empty || (state != ST_IDLE);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves CPU_WAIT unassigned (no latch).
        CPU_WAIT = 1'b0;
        case (CPU_ADDR)
            2'd0, 2'd1: CPU_WAIT = fifo_full;
            2'd2:       CPU_WAIT = !OKI_WE;
            default:    CPU_WAIT = 1'b0;
        endcase
    end

    // NOTE: the storage array has no reset; resetting the pointers is what discards its contents.
    always_ff @(posedge CLK96) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {CPU_ADDR[0], CPU_DIN};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state         <= ST_IDLE;
            ym_cnt        <= '0;
            YM2151_CS     <= 1'b0;
            YM2151_WE     <= 1'b1;
            YM2151_WR_CMD <= 1'b0;
            YM2151_DIN    <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state  <= ST_CHECK;
                        ym_cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (ym_go) begin
                        state         <= ST_STROBE;
                        ym_cnt        <= '0;
                        YM2151_CS     <= 1'b1;
                        YM2151_WE     <= 1'b0;
                        YM2151_WR_CMD <= fifo_head[8];
                        YM2151_DIN    <= fifo_head[7:0];
                    end else begin
                        ym_cnt <= ym_cnt + 1'b1;
                    end
                end
                ST_STROBE: begin
                    // DIN/WR_CMD are left untouched here so they outlive the strobe.
                    if (ym_cnt == HOLD_LAST) begin
                        YM2151_CS <= 1'b0;
                        YM2151_WE <= 1'b1;
                        ym_cnt    <= '0;
                        state     <= YM2151_WR_CMD ? ST_SETTLE : ST_IDLE;
                    end else begin
                        ym_cnt <= ym_cnt + 1'b1;
                    end
                end
                default: begin
                    if (ym_cnt == SETTLE_LAST) begin
                        state  <= ST_IDLE;
                        ym_cnt <= '0;
                    end else begin
                        ym_cnt <= ym_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            OKI_WE   <= 1'b1;
            OKI_DIN  <= 8'd0;
            oki_cnt  <= '0;
            OKI_BANK <= 1'b0;
        end else begin
            if (oki_wr_req && OKI_WE) begin
                OKI_WE  <= 1'b0;
                OKI_DIN <= CPU_DIN;
                oki_cnt <= '0;
            end else if (!OKI_WE) begin
                if (oki_cnt == HOLD_LAST) begin
                    OKI_WE <= 1'b1;
                end else begin
                    oki_cnt <= oki_cnt + 1'b1;
                end
            end
            if (CPU_WR && (CPU_ADDR == 2'd3)) begin
                OKI_BANK <= CPU_DIN[0];
            end
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            DROP     <= 1'b0;
            CPU_DOUT <= 8'd0;
        end else begin
            if ((ym_wr_req && !fifo_push) || (oki_wr_req && !OKI_WE)) begin
                DROP <= 1'b1;
            end
            if (CPU_RD) begin
                case (CPU_ADDR)
                    2'd0, 2'd1: CPU_DOUT <= {YM2151_DOUT[7] | ym_pending, YM2151_DOUT[6:0]};
                    2'd2:       CPU_DOUT <= OKI_DOUT;
                    default:    CPU_DOUT <= {7'd0, OKI_BANK};
                endcase
            end
        end
    end

endmodule
